mb_rtu_rx: RTL



---
 rtl/mb_rtu_pkg.sv | 33 +++
 rtl/mb_crc16.sv | 18 +
 rtl/mb_rtu_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mb_rtu_pkg.sv
// Shared Modbus RTU definitions: function codes, CRC constants, error codes,
// frame-parser states and the byte-wide CRC16 step.
package mb_rtu_pkg;

  localparam logic [7:0]  FUN_RD_HOLD   = 8'h03;
  localparam logic [7:0]  FUN_WR_SINGLE = 8'h06;
  localparam logic [7:0]  FUN_WR_MULTI  = 8'h10;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  localparam logic [1:0]  ERR_CRC = 2'd1;
  localparam logic [1:0]  ERR_FUN = 2'd2;
  localparam logic [1:0]  ERR_LEN = 2'd3;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_DISCARD
  } mb_state_e;

  // Reflected CRC16, LSB first, one whole byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/mb_crc16.sv
// Modbus CRC16 accumulator, one byte per clock. clr together with en seeds
// the register with the current byte so a new frame can start without a gap.
module mb_crc16 import mb_rtu_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= CRC_INIT;
    else if (en)  crc <= crc16_byte(clr ? CRC_INIT : crc, din);
    else if (clr) crc <= CRC_INIT;
  end

endmodule

// File: rtl/mb_rtu_rx.sv
// Modbus RTU request receiver: frames by T3.5 silence, checks address,
// function, length and CRC, and streams 0x10 payload bytes as they arrive.
module mb_rtu_rx import mb_rtu_pkg::*; #(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         T35_CYC    = 200521,
  parameter int         MAX_FRAME  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mb_rxd,
  input  logic        mb_rx_valid,
  output logic        rx_done,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic [7:0]  mb_fun,
  output logic [15:0] mb_addr,
  output logic [15:0] mb_num,
  output logic        mb_bcast,
  output logic [7:0]  wr_data,
  output logic        wr_data_valid
);

  localparam int TW = $clog2(T35_CYC + 1);
  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam logic [TW-1:0] T35  = TW'(T35_CYC);
  localparam logic [CW-1:0] CMAX = CW'(MAX_FRAME);

  mb_state_e     state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic [7:0]    f_fun, f_n;
  logic [15:0]   f_addr, f_num;
  logic          f_bcast;
  logic [15:0]   crc;
  logic          silence, start, crc_en, fun_ok, len_ok, payload;

  assign silence = (timer == T35);
  // IDLE and the single CHECK cycle both accept byte 0 of a new frame
  assign start   = mb_rx_valid && (state == ST_IDLE || state == ST_CHECK);
  assign crc_en  = start || (mb_rx_valid && state == ST_RECV && !silence && cnt != CMAX);

  mb_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (crc_en),
    .din   (mb_rxd),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timer <= '0;
    else if (mb_rx_valid) timer <= '0;
    else if (!silence)    timer <= timer + TW'(1);
  end

  always_comb begin
    fun_ok = (f_fun == FUN_RD_HOLD) || (f_fun == FUN_WR_SINGLE) || (f_fun == FUN_WR_MULTI);
    if (f_fun == FUN_WR_MULTI)
      len_ok = (16'(cnt) == 16'd9 + 16'(f_n)) && (16'(f_n) == (f_num << 1)) &&
               (f_num >= 16'd1) && (f_num <= 16'd123);
    else
      len_ok = (16'(cnt) == 16'd8);
    payload = (f_fun == FUN_WR_MULTI) && (cnt >= CW'(7)) &&
              (16'(cnt) <= 16'd6 + 16'(f_n));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SYNC;
      cnt           <= '0;
      f_fun         <= '0;
      f_n           <= '0;
      f_addr        <= '0;
      f_num         <= '0;
      f_bcast       <= 1'b0;
      rx_done       <= 1'b0;
      rx_err        <= 1'b0;
      err_code      <= '0;
      mb_fun        <= '0;
      mb_addr       <= '0;
      mb_num        <= '0;
      mb_bcast      <= 1'b0;
      wr_data       <= '0;
      wr_data_valid <= 1'b0;
    end else begin
      rx_done       <= 1'b0;
      rx_err        <= 1'b0;
      wr_data_valid <= 1'b0;
      case (state)
        ST_SYNC: if (silence) state <= ST_IDLE;

        ST_IDLE, ST_CHECK: begin
          if (mb_rx_valid) begin
            cnt     <= CW'(1);
            f_fun   <= '0;
            f_n     <= '0;
            f_addr  <= '0;
            f_num   <= '0;
            f_bcast <= (mb_rxd == 8'h00);
            state   <= (mb_rxd == SLAVE_ADDR || mb_rxd == 8'h00) ? ST_RECV : ST_DISCARD;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RECV: begin
          if (silence) begin
            state <= ST_CHECK;
            if (!fun_ok) begin
              rx_err   <= 1'b1;
              err_code <= ERR_FUN;
            end else if (!len_ok) begin
              rx_err   <= 1'b1;
              err_code <= ERR_LEN;
            end else if (crc != 16'h0000) begin
              rx_err   <= 1'b1;
              err_code <= ERR_CRC;
            end else begin
              rx_done  <= 1'b1;
              mb_fun   <= f_fun;
              mb_addr  <= f_addr;
              mb_num   <= f_num;
              mb_bcast <= f_bcast;
            end
          end else if (mb_rx_valid) begin
            if (cnt == CMAX) begin
              state    <= ST_DISCARD;
              rx_err   <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              cnt <= cnt + CW'(1);
              case (cnt)
                CW'(1): f_fun        <= mb_rxd;
                CW'(2): f_addr[15:8] <= mb_rxd;
                CW'(3): f_addr[7:0]  <= mb_rxd;
                CW'(4): f_num[15:8]  <= mb_rxd;
                CW'(5): f_num[7:0]   <= mb_rxd;
                CW'(6): f_n          <= mb_rxd;
                default: ;
              endcase
              // forwarded before the CRC is known; the consumer commits on rx_done
              if (payload) begin
                wr_data       <= mb_rxd;
                wr_data_valid <= 1'b1;
              end
            end
          end
        end

        ST_DISCARD: if (silence) state <= ST_IDLE;

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
